// File: rtl/div_32.sv
// ============================================================================
// Module   : div_32
// Purpose  : Multicycle signed divider, one restoring radix-2 step per clock.
//            Optional remainder output is enabled by defining DIV_REMAINDER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvsr_q;
  logic               qneg_q;
`ifdef DIV_REMAINDER_EN
  logic               rneg_q;
`endif

  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;
  logic               b_zero_d;
  logic [WIDTH:0]     shift_rem_d;
  logic [WIDTH:0]     trial_d;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   quo_fix_d;

  // Magnitude of the most negative value stays correct read as unsigned.
  always_comb begin
    a_mag_d  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag_d  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    b_zero_d = (data_operandB == '0);
  end

  always_comb begin
    shift_rem_d = {rem_q, quo_q[WIDTH-1]};
    trial_d     = shift_rem_d - {1'b0, dvsr_q};
    rem_d       = trial_d[WIDTH] ? shift_rem_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
    quo_d       = {quo_q[WIDTH-2:0], ~trial_d[WIDTH]};
    quo_fix_d   = qneg_q ? -quo_q : quo_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvsr_q         <= '0;
      qneg_q         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
`ifdef DIV_REMAINDER_EN
      rneg_q         <= 1'b0;
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_div) begin
        cnt_q <= '0;
        rem_q <= '0;
        if (b_zero_d) begin
          // Zeroed datapath lets DONE publish a zero quotient/remainder.
          state_q        <= S_DONE;
          quo_q          <= '0;
          dvsr_q         <= '0;
          qneg_q         <= 1'b0;
          data_result    <= '0;
          data_exception <= 1'b1;
          busy           <= 1'b0;
`ifdef DIV_REMAINDER_EN
          rneg_q         <= 1'b0;
`endif
        end else begin
          state_q        <= S_CALC;
          quo_q          <= a_mag_d;
          dvsr_q         <= b_mag_d;
          qneg_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          data_exception <= 1'b0;
          busy           <= 1'b1;
`ifdef DIV_REMAINDER_EN
          rneg_q         <= data_operandA[WIDTH-1];
`endif
        end
      end else begin
        case (state_q)
          S_CALC: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
              state_q <= S_DONE;
              busy    <= 1'b0;
            end
          end
          S_DONE: begin
            data_resultRDY <= 1'b1;
            data_result    <= quo_fix_d;
            state_q        <= S_IDLE;
`ifdef DIV_REMAINDER_EN
            data_remainder <= rneg_q ? -rem_q : rem_q;
`endif
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_32.sv
// ============================================================================
// Module   : tb_div_32
// Purpose  : Scoreboard bench for div_32 (remainder checked if DIV_REMAINDER_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_32;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_div;
  logic [31:0] opa, opb, res;
  logic        exc, rdy, busy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] remo;
`endif

  always #5 clock = ~clock;

  div_32 #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_div       (ctrl_div),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .data_result    (res),
    .data_exception (exc),
    .data_resultRDY (rdy),
    .busy           (busy)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder (remo)
`endif
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        exc;
    int          at_edge;
  } exp_t;

  exp_t sb[$];
  int   edges    = 0;
  int   checks   = 0;
  int   failures = 0;
  logic prev_rdy = 1'b0;

  always @(posedge clock) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edges);
    end
  endtask

  // Monitor: every result pulse is matched against the oldest expectation.
  always @(negedge clock) begin : mon
    exp_t e;
    if (rdy) begin
      chk("rdy_back_to_back", {31'b0, prev_rdy}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_rdy", {31'b0, rdy}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("latency_edge", 32'(edges), 32'(e.at_edge));
        chk("quotient", res, e.q);
        chk("exception", {31'b0, exc}, {31'b0, e.exc});
`ifdef DIV_REMAINDER_EN
        chk("remainder", remo, e.r);
`endif
      end
    end
    prev_rdy = rdy;
  end

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                       input logic [31:0] er, input logic ee, input bit replace);
    @(posedge clock);
    #1;
    opa      = a;
    opb      = b;
    ctrl_div = 1'b1;
    if (replace && sb.size() > 0) void'(sb.pop_back());
    sb.push_back('{q: eq, r: er, exc: ee, at_edge: edges + 1 + ((b == 32'd0) ? 1 : 33)});
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    opa      = $urandom;
    opb      = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input logic ee);
    issue(a, b, eq, er, ee, 1'b0);
    if (b != 32'd0) begin
      for (int i = 0; i < 32; i++) begin
        @(negedge clock);
        chk("busy_calc", {31'b0, busy}, 32'd1);
      end
    end else begin
      @(negedge clock);
      chk("busy_div0", {31'b0, busy}, 32'd0);
    end
    wait_drain();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_result"}, res, 32'd0);
    chk({tag, "_exception"}, {31'b0, exc}, 32'd0);
    chk({tag, "_rdy"}, {31'b0, rdy}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
`ifdef DIV_REMAINDER_EN
    chk({tag, "_remainder"}, remo, 32'd0);
`endif
  endtask

  initial begin : stim
    logic [31:0] ra, rb, rq, rr;
    reset_n  = 1'b0;
    ctrl_div = 1'b0;
    opa      = 32'd0;
    opb      = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_cleared("reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    do_div(32'd100,         32'd7,         32'd14,        32'd2,         1'b0);
    do_div(32'hFFFF_FF9C,   32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    do_div(32'd100,         32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0);
    do_div(32'hFFFF_FF9C,   32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0);
    do_div(32'd5,           32'd0,         32'd0,         32'd0,         1'b1);
    do_div(32'd9,           32'd3,         32'd3,         32'd0,         1'b0);
    do_div(32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
    do_div(32'h7FFF_FFFF,   32'd1,         32'h7FFF_FFFF, 32'd0,         1'b0);
    do_div(32'd0,           32'd5,         32'd0,         32'd0,         1'b0);
    do_div(32'd3,           32'd10,        32'd0,         32'd3,         1'b0);

    // Restart: second start lands ten edges after the first.
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    repeat (8) @(posedge clock);
    issue(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1);
    wait_drain();
    chk("restart_result_hold", res, 32'd10);

    // Reset in the middle of a division.
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    repeat (19) @(posedge clock);
    #1;
    reset_n = 1'b0;
    sb.delete();
    @(posedge clock);
    @(negedge clock);
    check_cleared("midreset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    @(negedge clock);
    check_cleared("post_reset");

    for (int i = 0; i < 250; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = 32'($urandom_range(1, 20));
        1: rb = -32'($urandom_range(1, 20));
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (i % 50 == 7) rb = 32'd0;
      if (i % 50 == 13) ra = 32'h8000_0000;
      ref_div(ra, rb, rq, rr);
      do_div(ra, rb, rq, rr, (rb == 32'd0));
    end

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
